// File: rtl/fifo_rr_scheduler_if.sv
// Scheduler-side bundle: FIFO status/data in, pop strobes and forwarded word out.
// master = scheduler, slave = FIFO bank plus downstream consumer.
interface fifo_rr_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic                  init;
  logic [N-1:0]          fifo_empty;
  logic [N-1:0]          fifo_overflow;
  logic [N-1:0][W-1:0]   fifo_data;
  logic                  pausa;
  logic [N-1:0]          fifo_pop;
  logic [W-1:0]          out_data;
  logic                  out_valid;
  logic [IW-1:0]         grant_id;
  logic                  idle;
  logic                  error;

  modport master (
    input  init, fifo_empty, fifo_overflow, fifo_data, pausa,
    output fifo_pop, out_data, out_valid, grant_id, idle, error
  );

  modport slave (
    output init, fifo_empty, fifo_overflow, fifo_data, pausa,
    input  fifo_pop, out_data, out_valid, grant_id, idle, error
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin pop scheduler over N FWFT FIFOs with registered output and sticky overflow error.
// Define SCHED_BURST_EN to hold a grant for up to BURST_LEN consecutive pops.

// Per-FIFO request qualifier: live request, and whether it sits at/above the rotation pointer.
module fifo_rr_lane #(
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic          empty,
  input  logic [IW-1:0] rr_ptr,
  output logic          req,
  output logic          hi
);
  localparam logic [IW-1:0] IDX_V = IW'(IDX);

  assign req = !empty;
  assign hi  = !empty && (IDX_V >= rr_ptr);
endmodule

module fifo_rr_scheduler #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  fifo_rr_scheduler_if.master     bus
);
  localparam int IW = $clog2(N);

  generate
    if (N < 2)         begin : g_chk_n  $error("N must be >= 2");         end
    if (BURST_LEN < 1) begin : g_chk_bl $error("BURST_LEN must be >= 1"); end
  endgenerate

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] id;
  } resp_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, sel, sel_inc, ptr_nxt;
  logic [N-1:0]  req, hi;
  logic          hit, any_req, any_ovf, pop_en;
  resp_t         resp_q;
  logic          out_vld;

  for (genvar i = 0; i < N; i++) begin : g_lane
    fifo_rr_lane #(.IW(IW), .IDX(i)) u_lane (
      .empty  (bus.fifo_empty[i]),
      .rr_ptr (rr_ptr),
      .req    (req[i]),
      .hi     (hi[i])
    );
  end

  assign any_req = |req;
  assign any_ovf = |bus.fifo_overflow;

  // Lowest requester at/above the pointer wins; otherwise wrap to the lowest requester.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (hi[i] && !hit) begin sel = IW'(i); hit = 1'b1; end
    for (int i = 0; i < N; i++)
      if (req[i] && !hit) begin sel = IW'(i); hit = 1'b1; end
  end

  assign sel_inc = (sel == IW'(N-1)) ? '0 : sel + IW'(1);

  // Overflow suppresses the pop in the same cycle it is seen.
  assign pop_en = (state == S_ACTIVE) && !bus.pausa && !any_ovf && any_req;

  always_comb begin
    bus.fifo_pop = '0;
    if (pop_en) bus.fifo_pop[sel] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   if (bus.init) state_nxt = S_IDLE;
      S_IDLE:   if (any_ovf) state_nxt = S_ERROR;
                else if (any_req) state_nxt = S_ACTIVE;
      S_ACTIVE: if (any_ovf) state_nxt = S_ERROR;
                else if (!any_req) state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

`ifdef SCHED_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  logic [CW-1:0] burst_cnt, burst_base;
  logic          burst_last;

  // A grant that moved off rr_ptr (held FIFO drained) starts a fresh burst.
  assign burst_base = (sel == rr_ptr) ? burst_cnt : '0;
  assign burst_last = (burst_base == CW'(BURST_LEN - 1));
  assign ptr_nxt    = burst_last ? sel_inc : sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     burst_cnt <= '0;
    else if (pop_en)               burst_cnt <= burst_last ? '0 : burst_base + CW'(1);
    else if (state_nxt == S_IDLE)  burst_cnt <= '0;
  end
`else
  assign ptr_nxt = sel_inc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      resp_q  <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= pop_en;
      if (pop_en) begin
        rr_ptr      <= ptr_nxt;
        resp_q.data <= bus.fifo_data[sel];
        resp_q.id   <= sel;
      end
    end
  end

  assign bus.out_data  = resp_q.data;
  assign bus.grant_id  = resp_q.id;
  assign bus.out_valid = out_vld;
  assign bus.idle      = (state == S_IDLE);
  assign bus.error     = (state == S_ERROR);
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler (N=4, W=8): vector table plus reset/idle/burst sequences.
module tb_fifo_rr_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  fifo_rr_scheduler_if #(.N(4), .W(8)) bus ();

  fifo_rr_scheduler #(.N(4), .W(8), .BURST_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        init;
    logic        pausa;
    logic [3:0]  empty;
    logic [3:0]  ovf;
    logic [31:0] data;
    logic [3:0]  pop;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  gid;
    logic        idle;
    logic        err;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(logic in, logic pa, logic [3:0] e, logic [3:0] o, logic [31:0] d,
                              logic [3:0] p, logic v, logic [7:0] od, logic [1:0] g,
                              logic id, logic er);
    vec_t r;
    r.init = in; r.pausa = pa; r.empty = e; r.ovf = o; r.data = d;
    r.pop = p; r.ov = v; r.od = od; r.gid = g; r.idle = id; r.err = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  int exp_g [8];
  int c0, c3;

  initial begin
    // in, pa, empty, ovf, data        | pop, ov, od, gid, idle, err
    vt[0]  = mk(0,0,4'hF,4'h0,32'h0,        4'h0,0,8'h00,2'd0,0,0); // INIT holds
    vt[1]  = mk(0,0,4'hF,4'h2,32'h0,        4'h0,0,8'h00,2'd0,0,0); // overflow ignored in INIT
    vt[2]  = mk(1,0,4'hF,4'h0,32'h0,        4'h0,0,8'h00,2'd0,1,0);
    vt[3]  = mk(0,0,4'hF,4'h0,32'h0,        4'h0,0,8'h00,2'd0,1,0);
    vt[4]  = mk(0,0,4'hA,4'h0,32'h00C000A0, 4'h0,0,8'h00,2'd0,0,0); // IDLE -> ACTIVE
    vt[5]  = mk(0,0,4'hA,4'h0,32'h00C000A0, 4'h1,1,8'hA0,2'd0,0,0);
    vt[6]  = mk(0,0,4'hA,4'h0,32'h00C000A1, 4'h4,1,8'hC0,2'd2,0,0);
    vt[7]  = mk(0,0,4'hA,4'h0,32'h00C100A1, 4'h1,1,8'hA1,2'd0,0,0);
    vt[8]  = mk(0,0,4'hB,4'h0,32'h00C10000, 4'h4,1,8'hC1,2'd2,0,0);
    vt[9]  = mk(0,0,4'hF,4'h0,32'h0,        4'h0,0,8'hC1,2'd2,1,0); // back to IDLE, ptr=3
    vt[10] = mk(0,0,4'h0,4'h0,32'h13121110, 4'h0,0,8'hC1,2'd2,0,0);
    vt[11] = mk(0,0,4'h0,4'h0,32'h13121110, 4'h8,1,8'h13,2'd3,0,0);
    vt[12] = mk(0,0,4'h0,4'h0,32'h13121110, 4'h1,1,8'h10,2'd0,0,0);
    vt[13] = mk(0,1,4'h0,4'h0,32'h13121110, 4'h0,0,8'h10,2'd0,0,0); // pause
    vt[14] = mk(0,1,4'h0,4'h0,32'h13121110, 4'h0,0,8'h10,2'd0,0,0);
    vt[15] = mk(0,1,4'h0,4'h0,32'h13121110, 4'h0,0,8'h10,2'd0,0,0);
    vt[16] = mk(0,0,4'h0,4'h0,32'h13121110, 4'h2,1,8'h11,2'd1,0,0); // resumes at FIFO 1
    vt[17] = mk(0,0,4'h0,4'h0,32'h13121110, 4'h4,1,8'h12,2'd2,0,0);
    vt[18] = mk(0,0,4'h0,4'h2,32'h13121110, 4'h0,0,8'h12,2'd2,0,1); // overflow beats pop
    vt[19] = mk(1,0,4'h0,4'h0,32'h13121110, 4'h0,0,8'h12,2'd2,0,1);
    vt[20] = mk(0,0,4'h0,4'h0,32'h13121110, 4'h0,0,8'h12,2'd2,0,1);
    vt[21] = mk(1,0,4'hF,4'h0,32'h13121110, 4'h0,0,8'h12,2'd2,0,1);

    bus.init = 1'b0; bus.pausa = 1'b0; bus.fifo_empty = 4'hF;
    bus.fifo_overflow = 4'h0; bus.fifo_data = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.pop",   32'(bus.fifo_pop),  32'h0);
    chk("rst.valid", 32'(bus.out_valid), 32'h0);
    chk("rst.data",  32'(bus.out_data),  32'h0);
    chk("rst.gid",   32'(bus.grant_id),  32'h0);
    chk("rst.idle",  32'(bus.idle),      32'h0);
    chk("rst.error", 32'(bus.error),     32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.init = vt[i].init; bus.pausa = vt[i].pausa; bus.fifo_empty = vt[i].empty;
      bus.fifo_overflow = vt[i].ovf; bus.fifo_data = vt[i].data;
      #1;
      chk($sformatf("v%0d.pop", i), 32'(bus.fifo_pop), 32'(vt[i].pop));
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
      chk($sformatf("v%0d.data", i),  32'(bus.out_data),  32'(vt[i].od));
      chk($sformatf("v%0d.gid", i),   32'(bus.grant_id),  32'(vt[i].gid));
      chk($sformatf("v%0d.idle", i),  32'(bus.idle),      32'(vt[i].idle));
      chk($sformatf("v%0d.error", i), 32'(bus.error),     32'(vt[i].err));
    end
    chk("err.pre_reset", 32'(bus.error), 32'h1);

    // Idle with everything empty for 20 cycles
    bus.init = 1'b1; bus.pausa = 1'b0; bus.fifo_empty = 4'hF; bus.fifo_overflow = 4'h0;
    do_reset();
    chk("err.cleared", 32'(bus.error), 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d.idle", k),  32'(bus.idle),      32'h1);
      chk($sformatf("idle%0d.pop", k),   32'(bus.fifo_pop),  32'h0);
      chk($sformatf("idle%0d.valid", k), 32'(bus.out_valid), 32'h0);
    end

    // Mid-stream asynchronous reset
    bus.init = 1'b0; bus.fifo_empty = 4'h0; bus.fifo_data = 32'h13121110;
    @(posedge clk); #1;
    chk("ms.active", 32'(bus.idle), 32'h0);
    chk("ms.pop0", 32'(bus.fifo_pop), 32'h1);
    @(posedge clk); #1;
    chk("ms.data0", 32'(bus.out_data), 32'h10);
    chk("ms.pop1", 32'(bus.fifo_pop), 32'h2);
    @(posedge clk); #1;
    chk("ms.data1", 32'(bus.out_data), 32'h11);
    chk("ms.gid1",  32'(bus.grant_id), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("ms.rst.pop",   32'(bus.fifo_pop),  32'h0);
    chk("ms.rst.valid", 32'(bus.out_valid), 32'h0);
    chk("ms.rst.data",  32'(bus.out_data),  32'h0);
    chk("ms.rst.gid",   32'(bus.grant_id),  32'h0);
    chk("ms.rst.idle",  32'(bus.idle),      32'h0);
    chk("ms.rst.error", 32'(bus.error),     32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ms.init%0d.pop", k),   32'(bus.fifo_pop),  32'h0);
      chk($sformatf("ms.init%0d.valid", k), 32'(bus.out_valid), 32'h0);
      chk($sformatf("ms.init%0d.idle", k),  32'(bus.idle),      32'h0);
    end
    bus.init = 1'b1;
    @(posedge clk); #1;
    chk("ms.to_idle", 32'(bus.idle), 32'h1);
    bus.init = 1'b0;
    @(posedge clk); #1;
    chk("ms.ptr0.pop", 32'(bus.fifo_pop), 32'h1);
    @(posedge clk); #1;
    chk("ms.ptr0.gid",  32'(bus.grant_id), 32'h0);
    chk("ms.ptr0.data", 32'(bus.out_data), 32'h10);

`ifdef SCHED_BURST_EN
    // FIFO 0 holds 6 words, FIFO 3 holds 2
    exp_g = '{0, 0, 0, 0, 3, 3, 0, 0};
    c0 = 6; c3 = 2;
    bus.init = 1'b1; bus.fifo_empty = 4'hF; bus.fifo_data = 32'h33000000;
    do_reset();
    @(posedge clk); #1;
    bus.init = 1'b0;
    bus.fifo_empty = {c3 == 0, 2'b11, c0 == 0};
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      bus.fifo_empty = {c3 == 0, 2'b11, c0 == 0};
      #1;
      chk($sformatf("burst%0d.pop", k), 32'(bus.fifo_pop), 32'(1) << exp_g[k]);
      @(posedge clk); #1;
      chk($sformatf("burst%0d.gid", k),   32'(bus.grant_id),  32'(exp_g[k]));
      chk($sformatf("burst%0d.valid", k), 32'(bus.out_valid), 32'h1);
      if (exp_g[k] == 0) c0--; else c3--;
    end
    bus.fifo_empty = 4'hF;
    @(posedge clk); #1;
    chk("burst.idle", 32'(bus.idle), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
